fixed_dot_accumulator: RTL and testbench

//  Downstream consumer of the element-wise product vector stage. Each accepted

---
 rtl/fixed_dot_accumulator_pkg.sv | 12 +
 rtl/fixed_dot_accumulator_adder_tree.sv | 26 ++
 rtl/fixed_dot_accumulator.sv | 84 ++++++++
 tb/tb_fixed_dot_accumulator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_dot_accumulator_pkg.sv
// Shared helpers for the fixed-point dot-product accumulator.
// Holds the counter sizing function used by the top level.
package fixed_dot_accumulator_pkg;

    // Beat counter width: at least one bit even when a single beat forms a frame.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fixed_dot_accumulator_adder_tree.sv
// Combinational signed reduction of one product vector to a single sum.
// Every element is sign-extended to the full output width before adding.
module fixed_adder_tree
    import fixed_dot_accumulator_pkg::*;
#(
    parameter int IN_SIZE   = 4,
    parameter int IN_WIDTH  = 48,
    parameter int OUT_WIDTH = 52
) (
    input  logic signed [IN_WIDTH-1:0]  i_data [IN_SIZE],
    output logic signed [OUT_WIDTH-1:0] o_sum
);

    logic signed [OUT_WIDTH-1:0] w_sum;

    // Sum all sign-extended elements.
    always_comb begin
        w_sum = {OUT_WIDTH{1'b0}};
        for (int i = 0; i < IN_SIZE; i++) begin
            w_sum = w_sum + OUT_WIDTH'(i_data[i]);
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/fixed_dot_accumulator.sv
// Accumulates IN_DEPTH reduced beats into one signed dot product and emits it
// on a registered valid/ready port; non-last beats flow even while output stalls.
module fixed_dot_accumulator
    import fixed_dot_accumulator_pkg::*;
#(
    parameter  int IN_WIDTH  = 48,
    parameter  int IN_SIZE   = 4,
    parameter  int IN_DEPTH  = 4,
    localparam int OUT_WIDTH = IN_WIDTH + $clog2(IN_SIZE) + $clog2(IN_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int CNT_W = cnt_width(IN_DEPTH);

    logic signed [OUT_WIDTH-1:0] r_acc;
    logic        [CNT_W-1:0]     r_cnt;
    logic signed [OUT_WIDTH-1:0] r_data_out;
    logic                        r_data_out_valid;

    logic signed [OUT_WIDTH-1:0] w_tree_sum;
    logic signed [OUT_WIDTH-1:0] w_acc_next;
    logic                        w_last;
    logic                        w_accept;

    fixed_adder_tree #(
        .IN_SIZE  (IN_SIZE),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_tree (
        .i_data(data_in),
        .o_sum (w_tree_sum)
    );

    assign w_last        = (r_cnt == CNT_W'(IN_DEPTH - 1));
    assign data_in_ready = !w_last || !r_data_out_valid || data_out_ready;
    assign w_accept      = data_in_valid && data_in_ready;
    assign w_acc_next    = r_acc + w_tree_sum;

    // Partial sum and beat counter; cleared when a frame closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= {OUT_WIDTH{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept && w_last) begin
            r_acc <= {OUT_WIDTH{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
        end
    end

    // Output register: a closing beat reloads it even in the cycle the old result drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out       <= {OUT_WIDTH{1'b0}};
            r_data_out_valid <= 1'b0;
        end else if (w_accept && w_last) begin
            r_data_out       <= w_acc_next;
            r_data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            r_data_out       <= r_data_out;
            r_data_out_valid <= 1'b0;
        end else begin
            r_data_out       <= r_data_out;
            r_data_out_valid <= r_data_out_valid;
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_fixed_dot_accumulator.sv
// Directed bench: table of whole frames plus hand-written multi-cycle sequences,
// with a second instance covering the single-beat-per-frame configuration.
module tb_fixed_dot_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: 8-bit elements, 4 per beat, 3 beats per frame, 12-bit result
    logic signed [7:0]  din [4];
    logic               dvalid;
    logic               dready;
    logic signed [11:0] dout;
    logic               ovalid;
    logic               oready;

    fixed_dot_accumulator #(.IN_WIDTH(8), .IN_SIZE(4), .IN_DEPTH(3)) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(dvalid), .data_in_ready(dready),
        .data_out(dout), .data_out_valid(ovalid), .data_out_ready(oready)
    );

    // Single-beat frames: 10-bit result
    logic signed [7:0] din1 [4];
    logic              dvalid1;
    logic              dready1;
    logic signed [9:0] dout1;
    logic              ovalid1;
    logic              oready1;

    fixed_dot_accumulator #(.IN_WIDTH(8), .IN_SIZE(4), .IN_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_in(din1), .data_in_valid(dvalid1), .data_in_ready(dready1),
        .data_out(dout1), .data_out_valid(ovalid1), .data_out_ready(oready1)
    );

    typedef struct {
        string name;
        int    b [3][4];
        int    exp;
    } vec_t;

    vec_t vecs [5];
    int   n_vec = 0;
    int   n_err = 0;
    int   q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 4; i++) din[i] = 8'(v);
    endtask

    task automatic run_vec(input int idx);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) din[i] = 8'(vecs[idx].b[b][i]);
            dvalid = 1'b1;
            #1;
            chk({vecs[idx].name, "_rdy"}, int'(dready), 1);
            step();
            if (b < 2) chk({vecs[idx].name, "_early_valid"}, int'(ovalid), 0);
        end
        dvalid = 1'b0;
        chk({vecs[idx].name, "_valid"}, int'(ovalid), 1);
        chk({vecs[idx].name, "_data"}, int'(dout), vecs[idx].exp);
    endtask

    initial begin
        int s;
        vecs[0].name = "basic";
        vecs[0].b    = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -1, -1, -1}};
        vecs[0].exp  = 32;
        vecs[1].name = "min";
        vecs[1].b    = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128}, '{-128, -128, -128, -128}};
        vecs[1].exp  = -1536;
        vecs[2].name = "max";
        vecs[2].b    = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}, '{127, 127, 127, 127}};
        vecs[2].exp  = 1524;
        vecs[3].name = "mixed";
        vecs[3].b    = '{'{127, -128, 5, -3}, '{0, 0, 0, 0}, '{-7, 7, 100, -100}};
        vecs[3].exp  = 1;
        vecs[4].name = "neg";
        vecs[4].b    = '{'{-100, -100, -100, -100}, '{-100, -100, -100, -100}, '{-100, -100, -100, -100}};
        vecs[4].exp  = -1200;

        set_all(0);
        dvalid = 1'b0; oready = 1'b1;
        for (int i = 0; i < 4; i++) din1[i] = 8'sd0;
        dvalid1 = 1'b0; oready1 = 1'b1;

        // Reset state
        step(); step();
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(ovalid), 0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", int'(dready), 1);
        chk("rst_rdy1", int'(dready1), 1);

        // Table of whole frames, downstream always ready
        for (int v = 0; v < 5; v++) run_vec(v);
        step();
        chk("drain_valid", int'(ovalid), 0);

        // Backpressure: result held, two non-last beats taken, closing beat stalled
        oready = 1'b0;
        run_vec(0);
        for (int c = 0; c < 6; c++) begin
            set_all(1);
            dvalid = 1'b1;
            #1;
            chk("bp_rdy", int'(dready), (c < 2) ? 1 : 0);
            chk("bp_hold_data", int'(dout), 32);
            chk("bp_hold_valid", int'(ovalid), 1);
            step();
        end
        oready = 1'b1;
        #1;
        chk("bp_release_rdy", int'(dready), 1);
        step();
        chk("bp_reload_valid", int'(ovalid), 1);
        chk("bp_reload_data", int'(dout), 12);
        dvalid = 1'b0;
        step();
        chk("bp_done_valid", int'(ovalid), 0);

        // Mid-frame reset discards the partial sum of 72
        set_all(9);
        dvalid = 1'b1;
        step(); step();
        dvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_dout", int'(dout), 0);
        chk("mrst_valid", int'(ovalid), 0);
        for (int b = 0; b < 3; b++) begin
            set_all(1);
            dvalid = 1'b1;
            step();
        end
        dvalid = 1'b0;
        chk("mrst_valid2", int'(ovalid), 1);
        chk("mrst_data", int'(dout), 12);

        // Streaming: 4 frames back to back, result every third cycle
        for (int k = 0; k < 12; k++) begin
            set_all((k % 3) + 1);
            dvalid = 1'b1;
            #1;
            chk("stream_rdy", int'(dready), 1);
            step();
            if (k % 3 == 2) begin
                chk("stream_valid", int'(ovalid), 1);
                chk("stream_data", int'(dout), 24);
            end else begin
                chk("stream_gap", int'(ovalid), 0);
            end
        end
        dvalid = 1'b0;

        // Single-beat frames back to back
        din1 = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        dvalid1 = 1'b1;
        #1;
        chk("d1_rdy0", int'(dready1), 1);
        step();
        chk("d1_valid_a", int'(ovalid1), 1);
        chk("d1_data_a", int'(dout1), 10);
        din1 = '{-8'sd4, -8'sd3, -8'sd2, -8'sd1};
        step();
        chk("d1_valid_b", int'(ovalid1), 1);
        chk("d1_data_b", int'(dout1), -10);
        dvalid1 = 1'b0;
        step();
        chk("d1_idle", int'(ovalid1), 0);

        // Random valid/ready toggling against a queue of expected sums
        for (int c = 0; c < 60; c++) begin
            dvalid1 = 1'($urandom_range(0, 1));
            oready1 = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) din1[i] = 8'($urandom_range(0, 255));
            #1;
            chk("d1r_rdy", int'(dready1), int'(!ovalid1 || oready1));
            if (ovalid1 && oready1 && q.size() > 0) begin
                chk("d1r_data", int'(dout1), q[0]);
                void'(q.pop_front());
            end
            if (dvalid1 && dready1) begin
                s = 0;
                for (int i = 0; i < 4; i++) s += int'(din1[i]);
                q.push_back(s);
            end
            step();
            chk("d1r_valid", int'(ovalid1), int'(q.size() != 0));
        end
        dvalid1 = 1'b0;
        oready1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (ovalid1 && q.size() > 0) begin
                chk("d1r_drain", int'(dout1), q[0]);
                void'(q.pop_front());
            end
            step();
        end
        chk("d1r_left", q.size(), 0);
        chk("d1r_final_valid", int'(ovalid1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
